key_trigger: RTL and testbench

- Upstream stage of the three-state sequencer (IDLE -> S1 -> S2 -> IDLE).
- Turns a raw, bouncing, active-low push-button into clean single-cycle start pulses on `en`.
- Holds at most one request while the sequencer is busy.
- Keeps saturating counts of accepted and dropped presses for debug LEDs.

---
 rtl/key_trigger_pkg.sv | 15 +
 rtl/key_debounce.sv | 87 ++++++++
 rtl/key_trigger.sv | 90 +++++++++
 tb/tb_key_trigger.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_trigger_pkg.sv
// Shared definitions for the push-button front ends: debounce state
// encodings and default timing constants.
package key_trigger_pkg;

   typedef enum logic [1:0] {
      REL  = 2'b00,
      PDEB = 2'b01,
      DOWN = 2'b10,
      RDEB = 2'b11
   } deb_state_e;

   localparam int DEB_CNT_DEF = 20;
   localparam int HOLD_DEF    = 2;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus debounce FSM for an active-low button.
// Emits a single-cycle press strobe once a press has been stable for
// DEB_CNT cycles; releases are debounced the same way but are silent.
//
//   state | meaning
//   ------+-----------------------------------------------
//   REL   | key released and stable
//   PDEB  | key seen low, counting stable-low cycles
//   DOWN  | press accepted, key held
//   RDEB  | key seen high, counting stable-high cycles
module key_debounce
   import key_trigger_pkg::*;
#(
   parameter int DEB_CNT = DEB_CNT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic press
);

   localparam int CNTW = $clog2(DEB_CNT);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEB_CNT - 1);

   logic            sync1_q;
   logic            key_s_q;
   deb_state_e      state_q;
   logic [CNTW-1:0] cnt_q;

   // Strobe fires on the last stable-low cycle, the same cycle PDEB exits to DOWN.
   assign press = (state_q == PDEB) && !key_s_q && (cnt_q == CNT_LAST);

   // Synchronizer; presets to "released" so reset never looks like a press.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         key_s_q <= 1'b1;
      end else begin
         sync1_q <= key_in;
         key_s_q <= sync1_q;
      end
   end

   // Debounce state machine with shared stability counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= REL;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            REL: begin
               if (!key_s_q) begin
                  state_q <= PDEB;
                  cnt_q   <= '0;
               end
            end
            PDEB: begin
               if (key_s_q) begin
                  state_q <= REL;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= DOWN;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DOWN: begin
               if (key_s_q) begin
                  state_q <= RDEB;
                  cnt_q   <= '0;
               end
            end
            RDEB: begin
               if (!key_s_q) begin
                  state_q <= DOWN;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= REL;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/key_trigger.sv
// Button-to-start-pulse front end for the sequencer. Debounced presses
// become one-cycle en pulses, spaced by a hold-off window; one press may
// wait while the sequencer is busy, further ones are counted as dropped.
module key_trigger
   import key_trigger_pkg::*;
#(
   parameter int DEB_CNT = DEB_CNT_DEF,
   parameter int HOLD    = HOLD_DEF,
   parameter int CW      = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          key_in,
   input  logic          busy,
   output logic          en,
   output logic          pend,
   output logic [CW-1:0] acc_cnt,
   output logic [CW-1:0] drop_cnt
);

   localparam int HW = $clog2(HOLD + 1);
   localparam logic [HW-1:0] HOLD_LD = HW'(HOLD);

   logic          press;
   logic          ok;
   logic          en_d;
   logic          pend_d;
   logic          drop_inc;
   logic          en_q;
   logic          pend_q;
   logic [HW-1:0] hold_q;
   logic [CW-1:0] acc_q;
   logic [CW-1:0] drop_q;

   key_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .key_in (key_in),
      .press  (press)
   );

   assign ok = !busy && (hold_q == '0);

   // Issue decision: serve now, queue one, or drop when the queue is full.
   always_comb begin
      en_d     = 1'b0;
      pend_d   = pend_q;
      drop_inc = 1'b0;
      if (press) begin
         if (ok) begin
            en_d = 1'b1;
         end else if (pend_q) begin
            drop_inc = 1'b1;
         end else begin
            pend_d = 1'b1;
         end
      end else if (pend_q && ok) begin
         en_d   = 1'b1;
         pend_d = 1'b0;
      end
   end

   // Output, hold-off and saturating counter registers; hold loads with the
   // pulse itself so the very next cycle is already blocked.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_q   <= 1'b0;
         pend_q <= 1'b0;
         hold_q <= '0;
         acc_q  <= '0;
         drop_q <= '0;
      end else begin
         en_q   <= en_d;
         pend_q <= pend_d;
         if (en_d) begin
            hold_q <= HOLD_LD;
            if (acc_q != '1) acc_q <= acc_q + 1'b1;
         end else if (hold_q != '0) begin
            hold_q <= hold_q - 1'b1;
         end
         if (drop_inc && (drop_q != '1)) drop_q <= drop_q + 1'b1;
      end
   end

   assign en       = en_q;
   assign pend     = pend_q;
   assign acc_cnt  = acc_q;
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_key_trigger.sv
// Self-checking bench for key_trigger: cycle scoreboard fed by a reference
// model, a scenario table, and directed latency/hold/reset/saturation cases.
module tb_key_trigger;

   localparam int DEB  = 4;
   localparam int HOLD = 2;
   localparam int CW   = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          key_in;
   logic          busy;
   logic          en;
   logic          pend;
   logic [CW-1:0] acc_cnt;
   logic [CW-1:0] drop_cnt;

   key_trigger #(.DEB_CNT(DEB), .HOLD(HOLD), .CW(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .key_in   (key_in),
      .busy     (busy),
      .en       (en),
      .pend     (pend),
      .acc_cnt  (acc_cnt),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int edge_n = 0;
   int en_count = 0;
   int last_en_edge = -1;
   int prev_en_edge = -1;

   always @(posedge clk) edge_n++;

   function automatic void chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, got, exp, edge_n);
      end
   endfunction

   // ---------------- reference model + scoreboard ----------------
   typedef struct packed {
      logic          en;
      logic          pend;
      logic [CW-1:0] acc;
      logic [CW-1:0] drop;
   } exp_t;

   exp_t sb_q[$];

   logic m_s1 = 1'b1, m_s2 = 1'b1;
   int   m_st = 0, m_cnt = 0, m_hold = 0, m_acc = 0, m_drop = 0;
   bit   m_en = 0, m_pend = 0;

   always @(posedge clk) begin
      bit strobe, ok, nen;
      exp_t e;
      if (rst) begin
         m_s1 = 1'b1; m_s2 = 1'b1; m_st = 0; m_cnt = 0;
         m_hold = 0; m_acc = 0; m_drop = 0; m_en = 0; m_pend = 0;
      end else begin
         strobe = (m_st == 1) && !m_s2 && (m_cnt == DEB - 1);
         ok     = !busy && (m_hold == 0);
         nen    = 0;
         if (strobe && !m_pend) begin
            if (ok) nen = 1; else m_pend = 1;
         end else if (strobe) begin
            if (ok) nen = 1;
            else if (m_drop < 255) m_drop++;
         end else if (m_pend && ok) begin
            nen = 1;
            m_pend = 0;
         end
         if (nen) begin
            m_hold = HOLD;
            if (m_acc < 255) m_acc++;
         end else if (m_hold > 0) begin
            m_hold--;
         end
         m_en = nen;
         case (m_st)
            0: if (!m_s2) begin m_st = 1; m_cnt = 0; end
            1: if (m_s2) m_st = 0;
               else if (m_cnt == DEB - 1) begin m_st = 2; m_cnt = 0; end
               else m_cnt++;
            2: if (m_s2) begin m_st = 3; m_cnt = 0; end
            3: if (!m_s2) m_st = 2;
               else if (m_cnt == DEB - 1) begin m_st = 0; m_cnt = 0; end
               else m_cnt++;
            default: m_st = 0;
         endcase
         m_s2 = m_s1;
         m_s1 = key_in;
      end
      e.en   = m_en;
      e.pend = m_pend;
      e.acc  = CW'(m_acc);
      e.drop = CW'(m_drop);
      sb_q.push_back(e);
   end

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         checks++;
         if ({en, pend, acc_cnt, drop_cnt} !== e) begin
            errors++;
            $display("FAIL scoreboard edge %0d: got en=%b pend=%b acc=%0d drop=%0d, expected en=%b pend=%b acc=%0d drop=%0d",
                     edge_n, en, pend, acc_cnt, drop_cnt, e.en, e.pend, e.acc, e.drop);
         end
      end
      if (en === 1'b1) begin
         if (last_en_edge >= 0) chk("en_spacing_ok", int'(edge_n - last_en_edge >= HOLD + 1), 1);
         prev_en_edge = last_en_edge;
         last_en_edge = edge_n;
         en_count++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Press with optional bounce on both edges; mark = edge sampling the final 1->0.
   task automatic press(input int bounce, output int mark);
      for (int i = 0; i < bounce; i++) begin
         key_in = (i % 2 == 0) ? 1'b0 : 1'b1;
         tick(1);
      end
      key_in = 1'b0;
      mark = edge_n + 1;
      tick(10);
      key_in = 1'b1;
      if (bounce > 0) begin
         for (int i = 0; i < 4; i++) begin
            tick(1);
            key_in = (i % 2 == 0) ? 1'b0 : 1'b1;
         end
      end
      tick(12);
   endtask

   typedef struct {
      int bounce;
      int npress;
      bit busy;
      int exp_pend;
      int exp_en;
      int exp_drop;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int mark, mark_b, en0, exp_acc, exp_drop, k2, n0;

      vecs[0] = '{0, 1, 1'b0, 0, 1, 0};
      vecs[1] = '{6, 1, 1'b0, 0, 1, 0};
      vecs[2] = '{0, 1, 1'b1, 1, 1, 0};
      vecs[3] = '{0, 2, 1'b1, 1, 1, 1};
      vecs[4] = '{0, 3, 1'b1, 1, 1, 2};

      rst = 1'b1; key_in = 1'b1; busy = 1'b0;
      tick(2);
      chk("reset_en", en, 0);
      chk("reset_pend", pend, 0);
      chk("reset_acc", acc_cnt, 0);
      chk("reset_drop", drop_cnt, 0);
      rst = 1'b0;
      tick(3);

      exp_acc = 0; exp_drop = 0;
      foreach (vecs[v]) begin
         busy = vecs[v].busy;
         en0 = en_count;
         for (int p = 0; p < vecs[v].npress; p++) press(vecs[v].bounce, mark);
         chk($sformatf("vec%0d_pend_busy", v), pend, vecs[v].exp_pend);
         if (vecs[v].busy) chk($sformatf("vec%0d_no_en_busy", v), en_count - en0, 0);
         busy = 1'b0;
         mark_b = edge_n + 1;
         tick(10);
         exp_acc  += vecs[v].exp_en;
         exp_drop += vecs[v].exp_drop;
         chk($sformatf("vec%0d_en_pulses", v), en_count - en0, vecs[v].exp_en);
         chk($sformatf("vec%0d_acc", v), acc_cnt, exp_acc);
         chk($sformatf("vec%0d_drop", v), drop_cnt, exp_drop);
         chk($sformatf("vec%0d_pend_after", v), pend, 0);
         if (vecs[v].busy) chk($sformatf("vec%0d_en_edge", v), last_en_edge, mark_b);
         else              chk($sformatf("vec%0d_latency", v), last_en_edge, mark + DEB + 2);
      end

      // Strobe one cycle after a pend-served en: queued, issued HOLD+1 later.
      busy = 1'b1;
      press(0, mark);
      chk("hold_pend_set", pend, 1);
      n0 = en_count;
      key_in = 1'b0;
      k2 = edge_n + 1;
      tick(5);
      busy = 1'b0;
      tick(8);
      chk("hold_first_en", prev_en_edge, k2 + DEB + 1);
      chk("hold_second_en", last_en_edge, k2 + DEB + 4);
      chk("hold_en_pulses", en_count - n0, 2);
      key_in = 1'b1;
      tick(12);
      chk("hold_pend_clear", pend, 0);

      // Reset in PDEB with a request pending discards everything.
      busy = 1'b1;
      press(0, mark);
      chk("rst_pre_pend", pend, 1);
      key_in = 1'b0;
      tick(3);
      rst = 1'b1; key_in = 1'b1; busy = 1'b0;
      tick(1);
      rst = 1'b0;
      chk("rst_en", en, 0);
      chk("rst_pend", pend, 0);
      chk("rst_acc", acc_cnt, 0);
      chk("rst_drop", drop_cnt, 0);
      n0 = en_count;
      tick(20);
      chk("rst_no_en", en_count - n0, 0);

      // Saturation of the accepted counter.
      for (int i = 0; i < 300; i++) begin
         key_in = 1'b0;
         tick(7);
         key_in = 1'b1;
         tick(7);
      end
      tick(12);
      chk("sat_pulses", en_count - n0, 300);
      chk("sat_acc", acc_cnt, 255);
      chk("sat_drop", drop_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
